// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 16-bit data memory between the CPU
// load/store path and the host port. Accesses are serialised with
// round-robin fairness, the memory read latency is sequenced by a small
// counter, and the CPU is stalled while its own access is outstanding.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  output logic        host_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT      = 2'(MEM_LATENCY);
  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_HOST = 1'b1;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_cnt;
  logic        r_owner;
  logic        r_last_owner;
  logic        r_we;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [15:0] r_mem_address;
  logic [15:0] r_mem_wdata;
  logic        r_cpu_gnt;
  logic        r_host_gnt;
  logic        r_cpu_rvalid;
  logic        r_host_rvalid;
  logic        r_cpu_done;
  logic        r_host_done;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_host_rdata;
  logic        r_busy;

  logic        w_cpu_vld;
  logic        w_host_vld;
  logic        w_win_host;
  logic        w_grant;
  logic        w_rd_done;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_wdata;

  // Arbitration and next-state decode; a requester whose rvalid is showing
  // this cycle is masked so a held req cannot re-issue the same access.
  always_comb begin
    w_cpu_vld    = cpu_req & ~r_cpu_rvalid;
    w_host_vld   = host_req & ~r_host_rvalid;
    w_win_host   = w_host_vld & (~w_cpu_vld | (r_last_owner == OWN_CPU));
    w_sel_we     = w_win_host ? host_we : cpu_we;
    w_sel_addr   = w_win_host ? host_addr : cpu_addr;
    w_sel_wdata  = w_win_host ? host_wdata : cpu_wdata;
    w_grant      = 1'b0;
    w_rd_done    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_vld | w_host_vld) begin
          w_grant      = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 2'd1) begin
          w_rd_done    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: latch the winner, drive strobes/grants for the ISSUE cycle,
  // count read latency and capture read data for the owner.
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      r_cnt         <= 2'd0;
      r_owner       <= OWN_CPU;
      r_last_owner  <= OWN_HOST;
      r_we          <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 16'h0000;
      r_mem_wdata   <= 16'h0000;
      r_cpu_gnt     <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_done    <= 1'b0;
      r_host_done   <= 1'b0;
      r_cpu_rdata   <= 16'h0000;
      r_host_rdata  <= 16'h0000;
      r_busy        <= 1'b0;
    end else begin
      r_cpu_gnt     <= w_grant & ~w_win_host;
      r_host_gnt    <= w_grant & w_win_host;
      r_mem_read    <= w_grant & ~w_sel_we;
      r_mem_write   <= w_grant & w_sel_we;
      r_cpu_rvalid  <= w_rd_done & (r_owner == OWN_CPU);
      r_host_rvalid <= w_rd_done & (r_owner == OWN_HOST);
      r_cpu_done    <= (w_grant & ~w_win_host & w_sel_we) | (w_rd_done & (r_owner == OWN_CPU));
      r_host_done   <= (w_grant & w_win_host & w_sel_we) | (w_rd_done & (r_owner == OWN_HOST));
      r_busy        <= (w_next_state != ST_IDLE);
      if (w_grant) begin
        r_owner       <= w_win_host;
        r_last_owner  <= w_win_host;
        r_we          <= w_sel_we;
        r_mem_address <= w_sel_addr;
        r_mem_wdata   <= w_sel_wdata;
      end else begin
        r_owner       <= r_owner;
        r_last_owner  <= r_last_owner;
      end
      if ((r_state == ST_ISSUE) && !r_we) begin
        r_cnt <= LAT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_rd_done && (r_owner == OWN_HOST)) begin
        r_host_rdata <= mem_read_data;
      end else if (w_rd_done) begin
        r_cpu_rdata <= mem_read_data;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
    end
  end

  assign cpu_gnt        = r_cpu_gnt;
  assign cpu_rvalid     = r_cpu_rvalid;
  assign cpu_rdata      = r_cpu_rdata;
  assign cpu_done       = r_cpu_done;
  assign cpu_stall      = cpu_req & ~r_cpu_done;
  assign host_gnt       = r_host_gnt;
  assign host_rvalid    = r_host_rvalid;
  assign host_rdata     = r_host_rdata;
  assign host_done      = r_host_done;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_wdata;
  assign busy           = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle-exact scenarios plus a randomized
// two-port run checked against a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        pc_reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_done, cpu_stall;
  logic        host_gnt, host_rvalid, host_done;
  logic [15:0] cpu_rdata, host_rdata;
  logic        mem_read, mem_write, busy;
  logic [15:0] mem_address, mem_write_data, mem_read_data;

  logic        d3_cpu_req, d3_cpu_we, d3_host_req, d3_host_we;
  logic [15:0] d3_cpu_addr, d3_cpu_wdata, d3_host_addr, d3_host_wdata;
  logic        d3_cpu_gnt, d3_cpu_rvalid, d3_cpu_done, d3_cpu_stall;
  logic        d3_host_gnt, d3_host_rvalid, d3_host_done;
  logic [15:0] d3_cpu_rdata, d3_host_rdata;
  logic        d3_mem_read, d3_mem_write, d3_busy;
  logic [15:0] d3_mem_address, d3_mem_write_data, d3_mem_read_data;

  int total = 0;
  int bad   = 0;
  bit overlap_seen = 1'b0;

  dmem_arbiter #(.MEM_LATENCY(L1)) u_dut (
    .clk(clk), .pc_reset(pc_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_done(host_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  dmem_arbiter #(.MEM_LATENCY(L3)) u_dut3 (
    .clk(clk), .pc_reset(pc_reset),
    .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
    .cpu_gnt(d3_cpu_gnt), .cpu_rvalid(d3_cpu_rvalid), .cpu_rdata(d3_cpu_rdata),
    .cpu_done(d3_cpu_done), .cpu_stall(d3_cpu_stall),
    .host_req(d3_host_req), .host_we(d3_host_we), .host_addr(d3_host_addr),
    .host_wdata(d3_host_wdata),
    .host_gnt(d3_host_gnt), .host_rvalid(d3_host_rvalid), .host_rdata(d3_host_rdata),
    .host_done(d3_host_done),
    .mem_read(d3_mem_read), .mem_write(d3_mem_write), .mem_address(d3_mem_address),
    .mem_write_data(d3_mem_write_data), .mem_read_data(d3_mem_read_data), .busy(d3_busy)
  );

  // Memory behind the latency-1 arbiter: data valid one cycle after the read strobe.
  logic [15:0] mem1 [0:255];
  logic [15:0] rd1;
  always @(posedge clk) begin
    if (mem_write) mem1[mem_address[7:0]] <= mem_write_data;
    rd1 <= mem_read ? mem1[mem_address[7:0]] : 16'h0000;
  end
  assign mem_read_data = rd1;

  // Memory behind the latency-3 arbiter: three-stage read pipeline.
  logic [15:0] mem3 [0:255];
  logic [15:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (d3_mem_write) mem3[d3_mem_address[7:0]] <= d3_mem_write_data;
    p3_0 <= d3_mem_read ? mem3[d3_mem_address[7:0]] : 16'h0000;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign d3_mem_read_data = p3_2;

  // Sticky record of any cycle with both memory strobes active.
  always @(negedge clk) begin
    if ((mem_read && mem_write) || (d3_mem_read && d3_mem_write)) overlap_seen <= 1'b1;
  end

  task automatic do_access(input bit host, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, output logic [15:0] rd,
                           output int lat, output bit ok);
    @(negedge clk);
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    ok = 1'b0; lat = 0; rd = 16'h0000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((host ? host_done : cpu_done) === 1'b1) begin
        ok = 1'b1; lat = i; rd = host ? host_rdata : cpu_rdata;
        break;
      end
    end
    if (host) host_req = 1'b0;
    else      cpu_req  = 1'b0;
  endtask

  task automatic test_reset();
    pc_reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
    d3_cpu_req = 1'b0; d3_cpu_we = 1'b0; d3_cpu_addr = 16'h0000; d3_cpu_wdata = 16'h0000;
    d3_host_req = 1'b0; d3_host_we = 1'b0; d3_host_addr = 16'h0000; d3_host_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_done, host_done, cpu_stall,
         mem_read, mem_write, busy, d3_busy} !== 11'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid,
               cpu_done, host_done, cpu_stall, mem_read, mem_write, busy, d3_busy});
    end
    total++;
    if ({mem_address, mem_write_data, cpu_rdata, host_rdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {mem_address, mem_write_data, cpu_rdata, host_rdata});
    end
    pc_reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    logic [15:0] rd; int lat; bit ok;
    do_access(1'b1, 1'b1, 16'h0010, 16'hBEEF, rd, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL preload_write got=timeout want=done"); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    total++;
    if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall c=0 got=%b want=1", cpu_stall); end
    for (int c = 1; c <= 2 + L1; c++) begin
      @(negedge clk);
      total++;
      if (cpu_gnt !== (c == 1)) begin
        bad++; $display("FAIL rd_gnt c=%0d got=%b want=%b", c, cpu_gnt, (c == 1));
      end
      total++;
      if (mem_read !== (c == 1) || mem_write !== 1'b0) begin
        bad++; $display("FAIL rd_strobe c=%0d got=%b%b want=%b0", c, mem_read, mem_write, (c == 1));
      end
      total++;
      if (cpu_rvalid !== (c == 2 + L1)) begin
        bad++; $display("FAIL rd_rvalid c=%0d got=%b want=%b", c, cpu_rvalid, (c == 2 + L1));
      end
      total++;
      if (cpu_stall !== (c != 2 + L1)) begin
        bad++; $display("FAIL rd_stall c=%0d got=%b want=%b", c, cpu_stall, (c != 2 + L1));
      end
      if (c == 1) begin
        total++;
        if (mem_address !== 16'h0010) begin
          bad++; $display("FAIL rd_addr got=%h want=0010", mem_address);
        end
      end
      if (c == 2 + L1) begin
        total++;
        if (cpu_rdata !== 16'hBEEF || cpu_done !== 1'b1) begin
          bad++; $display("FAIL rd_data got=%h done=%b want=beef done=1", cpu_rdata, cpu_done);
        end
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_write_then_read();
    logic [15:0] rd; int lat; bit ok;
    do_access(1'b1, 1'b1, 16'h0020, 16'h1234, rd, lat, ok);
    total++;
    if (!ok || lat != 1) begin bad++; $display("FAIL wr_latency got=%0d ok=%b want=1", lat, ok); end
    do_access(1'b0, 1'b0, 16'h0020, 16'h0000, rd, lat, ok);
    total++;
    if (!ok || rd !== 16'h1234) begin bad++; $display("FAIL wr_rd_data got=%h want=1234", rd); end
    total++;
    if (lat != 2 + L1) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, 2 + L1); end
    total++;
    if (overlap_seen) begin bad++; $display("FAIL strobe_overlap got=1 want=0"); end
  endtask

  task automatic test_held_req();
    logic [15:0] rd; int lat; bit ok;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 3) begin
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin
          bad++; $display("FAIL held_rvalid got=%b/%h want=1/1234", cpu_rvalid, cpu_rdata);
        end
      end
      if (c == 4) begin
        total++;
        if (cpu_gnt !== 1'b0 || busy !== 1'b0) begin
          bad++; $display("FAIL held_masked gnt=%b busy=%b want=0/0", cpu_gnt, busy);
        end
        cpu_we = 1'b1; cpu_addr = 16'h0021; cpu_wdata = 16'h5A5A;
      end
      if (c == 5) begin
        total++;
        if (cpu_gnt !== 1'b1 || mem_write !== 1'b1 || cpu_done !== 1'b1) begin
          bad++; $display("FAIL held_regrant gnt=%b wr=%b done=%b want=1/1/1", cpu_gnt, mem_write, cpu_done);
        end
      end
    end
    cpu_req = 1'b0;
    do_access(1'b1, 1'b0, 16'h0021, 16'h0000, rd, lat, ok);
    total++;
    if (!ok || rd !== 16'h5A5A || host_rdata !== 16'h5A5A) begin
      bad++; $display("FAIL held_write_data got=%h want=5a5a", rd);
    end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    pc_reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if ({cpu_gnt, cpu_rvalid, cpu_done, cpu_stall, mem_read, mem_write, busy, cpu_rdata} !== 23'h0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h want=0",
                      {cpu_gnt, cpu_rvalid, cpu_done, cpu_stall, mem_read, mem_write, busy, cpu_rdata});
    end
    pc_reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_rvalid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL mid_dropped_rvalid got=1 want=0"); end
  endtask

  task automatic test_simultaneous();
    int gcyc[$]; bit gwho[$];
    @(negedge clk);
    pc_reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h1111;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0031; host_wdata = 16'h2222;
    @(negedge clk);
    pc_reset = 1'b1;
    for (int c = 1; c <= 30 && gcyc.size() < 6; c++) begin
      @(negedge clk);
      if (cpu_gnt === 1'b1) begin gcyc.push_back(c); gwho.push_back(1'b0); end
      if (host_gnt === 1'b1) begin gcyc.push_back(c); gwho.push_back(1'b1); end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    total++;
    if (gcyc.size() != 6) begin
      bad++; $display("FAIL rr_count got=%0d want=6", gcyc.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (gwho[k] != k[0] || gcyc[k] != 2 * k + 1) begin
          bad++; $display("FAIL rr_order k=%0d got=%0d@%0d want=%0d@%0d", k, gwho[k], gcyc[k], k % 2, 2 * k + 1);
        end
      end
    end
  endtask

  task automatic test_latency3();
    @(negedge clk);
    d3_host_req = 1'b1; d3_host_we = 1'b1; d3_host_addr = 16'h0040; d3_host_wdata = 16'hCAFE;
    @(negedge clk);
    total++;
    if (d3_host_gnt !== 1'b1) begin bad++; $display("FAIL l3_wr_gnt got=%b want=1", d3_host_gnt); end
    d3_host_req = 1'b0;
    @(negedge clk);
    total++;
    if (d3_busy !== 1'b0) begin bad++; $display("FAIL l3_busy c=0 got=%b want=0", d3_busy); end
    d3_cpu_req = 1'b1; d3_cpu_we = 1'b0; d3_cpu_addr = 16'h0040;
    for (int c = 1; c <= 2 + L3; c++) begin
      @(negedge clk);
      total++;
      if (d3_busy !== (c <= 1 + L3)) begin
        bad++; $display("FAIL l3_busy c=%0d got=%b want=%b", c, d3_busy, (c <= 1 + L3));
      end
      total++;
      if (d3_cpu_rvalid !== (c == 2 + L3)) begin
        bad++; $display("FAIL l3_rvalid c=%0d got=%b want=%b", c, d3_cpu_rvalid, (c == 2 + L3));
      end
    end
    total++;
    if (d3_cpu_rdata !== 16'hCAFE) begin bad++; $display("FAIL l3_data got=%h want=cafe", d3_cpu_rdata); end
    d3_cpu_req = 1'b0;
  endtask

  task automatic test_random();
    bit act[2], granted[2], we_q[2], g[2], dn[2], rv[2];
    logic [15:0] addr_q[2], wd_q[2], exp_rd[2], rdv[2];
    bit exp_known[2];
    int due[2], start[2], others[2];
    logic [15:0] mdl_mem[8];
    bit known[8];
    int ndone = 0;
    for (int i = 0; i < 8; i++) known[i] = 1'b0;
    for (int p = 0; p < 2; p++) begin act[p] = 1'b0; granted[p] = 1'b0; end
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      g[0] = cpu_gnt;   g[1] = host_gnt;
      dn[0] = cpu_done; dn[1] = host_done;
      rv[0] = cpu_rvalid; rv[1] = host_rvalid;
      rdv[0] = cpu_rdata; rdv[1] = host_rdata;
      total++;
      if (cpu_stall !== (cpu_req & ~cpu_done) || (mem_read & mem_write) === 1'b1 || (g[0] & g[1])) begin
        bad++; $display("FAIL rnd_sanity cyc=%0d stall=%b rd=%b wr=%b g=%b%b", cyc, cpu_stall, mem_read, mem_write, g[0], g[1]);
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          total++;
          if (!act[p] || granted[p] || others[p] > 1 || mem_address !== addr_q[p] ||
              mem_write !== we_q[p] || mem_read !== !we_q[p]) begin
            bad++; $display("FAIL rnd_grant cyc=%0d port=%0d act=%b others=%0d addr=%h want=%h", cyc, p, act[p], others[p], mem_address, addr_q[p]);
          end
          granted[p] = 1'b1;
          if (act[1 - p] && !granted[1 - p]) others[1 - p]++;
          if (we_q[p]) begin
            mdl_mem[addr_q[p][2:0]] = wd_q[p]; known[addr_q[p][2:0]] = 1'b1; due[p] = cyc;
          end else begin
            exp_rd[p] = mdl_mem[addr_q[p][2:0]]; exp_known[p] = known[addr_q[p][2:0]]; due[p] = cyc + L1 + 1;
          end
        end
        if (dn[p] || rv[p]) begin
          total++;
          if (!act[p] || !granted[p] || cyc != due[p] || !dn[p] || rv[p] != !we_q[p] ||
              (rv[p] && exp_known[p] && rdv[p] !== exp_rd[p])) begin
            bad++; $display("FAIL rnd_done cyc=%0d port=%0d due=%0d rv=%b data=%h want=%h", cyc, p, due[p], rv[p], rdv[p], exp_rd[p]);
          end
          act[p] = 1'b0; ndone++;
        end
        if (act[p] && cyc - start[p] > 40) begin
          total++; bad++; act[p] = 1'b0;
          $display("FAIL rnd_timeout cyc=%0d port=%0d got=no_done want=done", cyc, p);
        end
        if (!act[p] && cyc < 1900 && $urandom_range(0, 3) == 0) begin
          act[p] = 1'b1; granted[p] = 1'b0; others[p] = 0; start[p] = cyc;
          we_q[p] = 1'($urandom_range(0, 1));
          addr_q[p] = 16'($urandom_range(0, 7));
          wd_q[p] = 16'($urandom);
        end
      end
      cpu_req = act[0];  cpu_we = we_q[0];  cpu_addr = addr_q[0];  cpu_wdata = wd_q[0];
      host_req = act[1]; host_we = we_q[1]; host_addr = addr_q[1]; host_wdata = wd_q[1];
    end
    total++;
    if (ndone < 100 || act[0] || act[1]) begin
      bad++; $display("FAIL rnd_activity got=%0d pending=%b%b want>=100 pending=00", ndone, act[0], act[1]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_then_read();
    test_held_req();
    test_reset_mid_read();
    test_simultaneous();
    test_latency3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
